// File: rtl/jogo_faixa_rodadas.sv
// Round controller for the distance-range game: drives range limits and measure pulses, scores hits.
// Optional macro JOGO_CONTINUA_APOS_ERRO_EN: a lost round advances to the next round instead of ending the game.
module jogo_faixa_rodadas #(
    parameter int INTERVALO      = 5000000,
    parameter int MAX_TENTATIVAS = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic        acertou,
    output logic        medir,
    output logic [11:0] lowerL,
    output logic [11:0] upperL,
    output logic [1:0]  rodada,
    output logic [2:0]  pontos,
    output logic        fim_jogo,
    output logic        ganhou,
    output logic [3:0]  db_estado
);

    localparam int               CNT_W    = $clog2(INTERVALO);
    localparam logic [CNT_W-1:0] CNT_ULT  = CNT_W'(INTERVALO - 1);
    localparam logic [7:0]       TENT_MAX = 8'(MAX_TENTATIVAS);

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        PREPARA = 4'd1,
        MEDE    = 4'd2,
        AGUARDA = 4'd3,
        ACERTO  = 4'd4,
        ERRO    = 4'd5,
        PROXIMA = 4'd6,
        FIM     = 4'd15
    } estado_t;

    estado_t          r_estado;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_tent;
    logic [1:0]       r_rodada;
    logic [2:0]       r_pontos;
    logic [11:0]      r_lower;
    logic [11:0]      r_upper;
    logic             r_medir;
    logic             r_fim;
    logic             r_ganhou;

    function automatic logic [11:0] lim_inf(input logic [1:0] idx);
        case (idx)
            2'd0:    lim_inf = 12'h010;
            2'd1:    lim_inf = 12'h030;
            2'd2:    lim_inf = 12'h050;
            default: lim_inf = 12'h015;
        endcase
    endfunction

    function automatic logic [11:0] lim_sup(input logic [1:0] idx);
        case (idx)
            2'd0:    lim_sup = 12'h020;
            2'd1:    lim_sup = 12'h045;
            2'd2:    lim_sup = 12'h060;
            default: lim_sup = 12'h025;
        endcase
    endfunction

    // Outputs are registered alongside the state so they change on the same edge as db_estado.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= INICIAL;
            r_cnt    <= '0;
            r_tent   <= 8'd0;
            r_rodada <= 2'd0;
            r_pontos <= 3'd0;
            r_lower  <= 12'h000;
            r_upper  <= 12'h000;
            r_medir  <= 1'b0;
            r_fim    <= 1'b0;
            r_ganhou <= 1'b0;
        end else begin
            r_medir <= 1'b0;
            case (r_estado)
                INICIAL: begin
                    if (iniciar) begin
                        r_rodada <= 2'd0;
                        r_pontos <= 3'd0;
                        r_lower  <= lim_inf(2'd0);
                        r_upper  <= lim_sup(2'd0);
                        r_estado <= PREPARA;
                    end
                end
                PREPARA: begin
                    r_cnt    <= '0;
                    r_tent   <= 8'd0;
                    r_medir  <= 1'b1;
                    r_estado <= MEDE;
                end
                MEDE: begin
                    r_tent   <= r_tent + 8'd1;
                    r_cnt    <= '0;
                    r_estado <= AGUARDA;
                end
                AGUARDA: begin
                    // A hit on the timeout cycle still counts: acertou is tested first.
                    if (acertou) begin
                        r_cnt    <= '0;
                        r_estado <= ACERTO;
                    end else if (r_cnt == CNT_ULT) begin
                        r_cnt <= '0;
                        if (r_tent == TENT_MAX) begin
                            r_estado <= ERRO;
                        end else begin
                            r_medir  <= 1'b1;
                            r_estado <= MEDE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ACERTO: begin
                    if (r_pontos != 3'd4)
                        r_pontos <= r_pontos + 3'd1;
                    r_estado <= PROXIMA;
                end
                ERRO: begin
`ifdef JOGO_CONTINUA_APOS_ERRO_EN
                    r_estado <= PROXIMA;
`else
                    r_fim    <= 1'b1;
                    r_ganhou <= 1'b0;
                    r_estado <= FIM;
`endif
                end
                PROXIMA: begin
                    if (r_rodada == 2'd3) begin
                        r_fim    <= 1'b1;
                        r_ganhou <= (r_pontos == 3'd4);
                        r_estado <= FIM;
                    end else begin
                        r_rodada <= r_rodada + 2'd1;
                        r_lower  <= lim_inf(r_rodada + 2'd1);
                        r_upper  <= lim_sup(r_rodada + 2'd1);
                        r_estado <= PREPARA;
                    end
                end
                FIM: begin
                    if (iniciar) begin
                        r_fim    <= 1'b0;
                        r_ganhou <= 1'b0;
                        r_lower  <= 12'h000;
                        r_upper  <= 12'h000;
                        r_estado <= INICIAL;
                    end
                end
                default: begin
                    r_cnt    <= '0;
                    r_tent   <= 8'd0;
                    r_fim    <= 1'b0;
                    r_ganhou <= 1'b0;
                    r_lower  <= 12'h000;
                    r_upper  <= 12'h000;
                    r_estado <= INICIAL;
                end
            endcase
        end
    end

    assign medir     = r_medir;
    assign lowerL    = r_lower;
    assign upperL    = r_upper;
    assign rodada    = r_rodada;
    assign pontos    = r_pontos;
    assign fim_jogo  = r_fim;
    assign ganhou    = r_ganhou;
    assign db_estado = r_estado;

endmodule

// File: tb/tb_jogo_faixa_rodadas.sv
// Bench for jogo_faixa_rodadas: directed table/sequences plus random play against a per-cycle game model.
`timescale 1ns/1ps
module tb_jogo_faixa_rodadas;

    localparam int INTERVALO = 10;
    localparam int MAX_T     = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        iniciar = 1'b0;
    logic        acertou = 1'b0;
    logic        medir;
    logic [11:0] lowerL;
    logic [11:0] upperL;
    logic [1:0]  rodada;
    logic [2:0]  pontos;
    logic        fim_jogo;
    logic        ganhou;
    logic [3:0]  db_estado;

    jogo_faixa_rodadas #(.INTERVALO(INTERVALO), .MAX_TENTATIVAS(MAX_T)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .acertou(acertou),
        .medir(medir), .lowerL(lowerL), .upperL(upperL), .rodada(rodada),
        .pontos(pontos), .fim_jogo(fim_jogo), .ganhou(ganhou), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    // Reference game model: rounds, score and the time elapsed since the last measure pulse.
    logic [11:0] tab_inf [4] = '{12'h010, 12'h030, 12'h050, 12'h015};
    logic [11:0] tab_sup [4] = '{12'h020, 12'h045, 12'h060, 12'h025};
    int          m_st = 0, m_rod = 0, m_pts = 0, m_tent = 0, m_dec = 0;
    logic [11:0] m_lo = 12'h000, m_hi = 12'h000;
    bit          mod_en = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_st = 0; m_rod = 0; m_pts = 0; m_tent = 0; m_dec = 0;
            m_lo = 12'h000; m_hi = 12'h000;
        end else begin
            case (m_st)
                0: if (iniciar) begin
                    m_rod = 0; m_pts = 0; m_lo = tab_inf[0]; m_hi = tab_sup[0]; m_st = 1;
                end
                1: begin m_tent = 0; m_st = 2; end
                2: begin m_tent = m_tent + 1; m_dec = 0; m_st = 3; end
                3: begin
                    m_dec = m_dec + 1;
                    if (acertou) m_st = 4;
                    else if (m_dec == INTERVALO) m_st = (m_tent == MAX_T) ? 5 : 2;
                end
                4: begin m_pts = m_pts + 1; m_st = 6; end
`ifdef JOGO_CONTINUA_APOS_ERRO_EN
                5: m_st = 6;
`else
                5: m_st = 15;
`endif
                6: if (m_rod == 3) m_st = 15;
                   else begin
                       m_rod = m_rod + 1; m_lo = tab_inf[m_rod]; m_hi = tab_sup[m_rod]; m_st = 1;
                   end
                15: if (iniciar) begin m_st = 0; m_lo = 12'h000; m_hi = 12'h000; end
                default: m_st = 0;
            endcase
        end
    end

    logic [35:0] v_dut, v_esp;
    always @(negedge clock) begin
        if (mod_en) begin
            v_dut = {medir, lowerL, upperL, rodada, pontos, fim_jogo, ganhou, db_estado};
            v_esp = {(m_st == 2), m_lo, m_hi, m_rod[1:0], m_pts[2:0], (m_st == 15),
                     (m_st == 15 && m_pts == 4), m_st[3:0]};
            check("modelo", {28'd0, v_dut}, {28'd0, v_esp});
        end
    end

    task automatic espera_medir(input string nome);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (medir !== 1'b1 && n < 200);
        check({nome, "_medir_visto"}, {63'd0, medir}, 64'd1);
    endtask

    task automatic espera_fim(input string nome);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (db_estado !== 4'hF && n < 300);
        check({nome, "_fim_visto"}, {60'd0, db_estado}, 64'hF);
    endtask

    task automatic novo_jogo();
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0; iniciar = 1'b1;
        @(negedge clock); iniciar = 1'b0;
    endtask

    task automatic acerta_rodada(input string nome);
        espera_medir(nome);
        repeat (3) @(negedge clock);
        acertou = 1'b1;
        @(negedge clock); acertou = 1'b0;
    endtask

    typedef struct {
        int          atraso;
        logic [11:0] lo;
        logic [11:0] hi;
        logic [2:0]  pts;
    } vet_t;
    vet_t tabela [4];

    initial begin
        int t_ult, n_pulsos, thr;
        tabela[0] = '{3,  12'h010, 12'h020, 3'd1};
        tabela[1] = '{1,  12'h030, 12'h045, 3'd2};
        tabela[2] = '{10, 12'h050, 12'h060, 3'd3};
        tabela[3] = '{3,  12'h015, 12'h025, 3'd4};

        // Reset state
        repeat (2) @(negedge clock);
        mod_en = 1'b1;
        reset = 1'b0;
        check("rst_estado", {60'd0, db_estado}, 64'd0);
        check("rst_medir", {63'd0, medir}, 64'd0);
        check("rst_limites", {40'd0, lowerL, upperL}, 64'd0);
        check("rst_rodada_pontos", {59'd0, rodada, pontos}, 64'd0);
        check("rst_fim_ganhou", {62'd0, fim_jogo, ganhou}, 64'd0);

        // All hits, table-driven
        iniciar = 1'b1;
        @(negedge clock); iniciar = 1'b0;
        for (int r = 0; r < 4; r++) begin
            espera_medir("tab");
            check("tab_lower", {52'd0, lowerL}, {52'd0, tabela[r].lo});
            check("tab_upper", {52'd0, upperL}, {52'd0, tabela[r].hi});
            check("tab_rodada", {62'd0, rodada}, r);
            repeat (tabela[r].atraso) @(negedge clock);
            acertou = 1'b1;
            @(negedge clock); acertou = 1'b0;
            check("tab_acerto", {60'd0, db_estado}, 64'd4);
            @(negedge clock);
            check("tab_pontos", {61'd0, pontos}, {61'd0, tabela[r].pts});
        end
        @(negedge clock);
        check("win_estado", {60'd0, db_estado}, 64'hF);
        check("win_flags", {62'd0, fim_jogo, ganhou}, 64'd3);
        check("win_pontos", {61'd0, pontos}, 64'd4);

        // Restart from FIM through INICIAL
        iniciar = 1'b1;
        @(negedge clock); iniciar = 1'b0;
        check("rei_inicial", {60'd0, db_estado}, 64'd0);
        check("rei_flags", {62'd0, fim_jogo, ganhou}, 64'd0);
        check("rei_limites", {40'd0, lowerL, upperL}, 64'd0);
        repeat (3) @(negedge clock);
        check("rei_espera", {60'd0, db_estado}, 64'd0);
        iniciar = 1'b1;
        @(negedge clock); iniciar = 1'b0;
        check("rei_prepara", {60'd0, db_estado}, 64'd1);
        check("rei_rodada_pontos", {59'd0, rodada, pontos}, 64'd0);
        check("rei_limites0", {40'd0, lowerL, upperL}, {40'd0, 12'h010, 12'h020});

        // Timeout with acertou held low
        espera_medir("tmo");
        t_ult = 0;
        n_pulsos = 1;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clock);
            if (medir === 1'b1) begin
                n_pulsos++;
                check("tmo_intervalo", c - t_ult, INTERVALO + 1);
                t_ult = c;
            end
        end
        check("tmo_pulsos", n_pulsos, MAX_T);
`ifdef JOGO_CONTINUA_APOS_ERRO_EN
        check("tmo_prox_rodada", {62'd0, rodada}, 64'd1);
        check("tmo_pontos", {61'd0, pontos}, 64'd0);
        check("tmo_estado", {60'd0, db_estado}, 64'd1);
`else
        check("tmo_estado", {60'd0, db_estado}, 64'hF);
        check("tmo_rodada", {62'd0, rodada}, 64'd0);
        check("tmo_flags", {62'd0, fim_jogo, ganhou}, 64'd2);
`endif

        // Hit on the last waiting cycle of the final attempt
        novo_jogo();
        espera_medir("sim1");
        espera_medir("sim2");
        espera_medir("sim3");
        repeat (INTERVALO) @(negedge clock);
        acertou = 1'b1;
        @(negedge clock); acertou = 1'b0;
        check("sim_acerto", {60'd0, db_estado}, 64'd4);
        @(negedge clock);
        check("sim_pontos", {61'd0, pontos}, 64'd1);

        // Stale acertou during PREPARA/MEDE and iniciar mid-game
        @(negedge clock);
        check("stale_prepara", {60'd0, db_estado}, 64'd1);
        acertou = 1'b1;
        @(negedge clock);
        check("stale_mede", {63'd0, medir}, 64'd1);
        @(negedge clock); acertou = 1'b0;
        check("stale_aguarda", {60'd0, db_estado}, 64'd3);
        @(negedge clock);
        check("stale_pontos", {61'd0, pontos}, 64'd1);
        iniciar = 1'b1;
        @(negedge clock); iniciar = 1'b0;
        check("ini_ignorado", {60'd0, db_estado}, 64'd3);
        check("ini_rodada", {62'd0, rodada}, 64'd1);
        espera_fim("stale");
        check("stale_fim_pontos", {61'd0, pontos}, 64'd1);
        check("stale_ganhou", {63'd0, ganhou}, 64'd0);
`ifdef JOGO_CONTINUA_APOS_ERRO_EN
        check("stale_rodada", {62'd0, rodada}, 64'd3);
`else
        check("stale_rodada", {62'd0, rodada}, 64'd1);
`endif

        // Reset while waiting in round 2
        novo_jogo();
        acerta_rodada("rr0");
        acerta_rodada("rr1");
        espera_medir("rr2");
        repeat (2) @(negedge clock);
        check("rr_rodada2", {62'd0, rodada}, 64'd2);
        reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        check("rr_estado", {60'd0, db_estado}, 64'd0);
        check("rr_medir", {63'd0, medir}, 64'd0);
        check("rr_limites", {40'd0, lowerL, upperL}, 64'd0);
        check("rr_rodada_pontos", {59'd0, rodada, pontos}, 64'd0);

        // Random play against the model
        thr = 4;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (c % 500 == 0) thr = 4 << (c / 500 % 3 * 2);
            iniciar = ($urandom_range(0, 3) == 0);
            acertou = ($urandom_range(0, thr - 1) == 0);
            reset   = ($urandom_range(0, 599) == 0);
        end
        @(negedge clock);
        iniciar = 1'b0; acertou = 1'b0; reset = 1'b0;
        repeat (4) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jogo_faixa_rodadas.md
Name: jogo_faixa_rodadas

Overview:
- Round controller directly upstream of the distance-range measurer.
- Per round: drives the measurer's lower/upper range limits, issues periodic one-cycle measure pulses, consumes its hit flag, keeps score.
- Four fixed rounds; ends in a won/lost final state visible to the top level and debug displays.

Parameters:
- INTERVALO, 5000000, clock cycles between consecutive measure pulses; minimum 2.
- MAX_TENTATIVAS, 20, measure pulses per round before the round is lost; range 1..255.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- iniciar  input  1  start/restart request, level-sampled
- acertou  input  1  hit flag from the measurer (measurement inside limits)
- medir  output  1  one-cycle measure request to the measurer
- lowerL  output  12  lower limit, 3-digit BCD
- upperL  output  12  upper limit, 3-digit BCD
- rodada  output  2  current round index 0..3
- pontos  output  3  rounds won 0..4
- fim_jogo  output  1  high in FIM
- ganhou  output  1  high in FIM when pontos == 4
- db_estado  output  4  current state code

Behaviour:
- One clock; reset synchronous active-high, priority over everything. Mid-operation it forces INICIAL and clears all counters in the same edge.
- Reset values: medir=0, lowerL=upperL=12'h000, rodada=0, pontos=0, fim_jogo=0, ganhou=0, db_estado=4'h0.
- Round table, BCD:
  - round 0: 12'h010..12'h020
  - round 1: 12'h030..12'h045
  - round 2: 12'h050..12'h060
  - round 3: 12'h015..12'h025
- lowerL/upperL are registered: updated on the PREPARA edge, held constant through the round. They read 000 only in INICIAL.
- Internal counters:
  - intervalo counter: width ceil(log2(INTERVALO)).
  - tentativas counter: 8 bits.
- States and codes:
  - INICIAL (0): wait for iniciar=1, then PREPARA. Clear pontos and rodada on exit.
  - PREPARA (1): load limits for rodada; zero both counters; go to MEDE.
  - MEDE (2): medir=1 for exactly this cycle; tentativas+1; go to AGUARDA.
  - AGUARDA (3): intervalo counts up.
    - acertou=1 in any cycle: go to ACERTO.
    - Otherwise, at count INTERVALO-1: go to ERRO if tentativas == MAX_TENTATIVAS, else back to MEDE.
    - If acertou=1 coincides with the timeout cycle, the hit wins.
  - ACERTO (4): pontos+1; go to PROXIMA.
  - ERRO (5): go to PROXIMA (see optional feature).
  - PROXIMA (6): if rodada == 3, go to FIM; else rodada+1, then PREPARA.
  - FIM (15): fim_jogo=1; ganhou=(pontos==4). iniciar=1 goes to INICIAL, which then restarts on the next iniciar.
- Unused codes 7..14 go to INICIAL.
- acertou is ignored outside AGUARDA, including while the measurer still holds a stale flag during PREPARA/MEDE.
- iniciar is ignored outside INICIAL/FIM.
- Measure pulse spacing is exactly INTERVALO+1 cycles: MEDE plus INTERVALO AGUARDA cycles.
- Latency from AGUARDA timeout to the next medir pulse: 1 cycle.
- pontos never exceeds 4; rodada never wraps during a game.

Optional Feature:
- Macro: JOGO_CONTINUA_APOS_ERRO_EN.
- Defined: ERRO goes to PROXIMA; all four rounds are always played and the score counts hits.
- Undefined: ERRO goes directly to FIM. The game ends at the first lost round with ganhou=0, and rodada holds the failed round index.

Test Plan (INTERVALO=10, MAX_TENTATIVAS=3):
- Reset mid-round:
  - Stimulus: reset=1 for one cycle while in AGUARDA of round 2.
  - Required: next cycle db_estado=0, medir=0, lowerL=upperL=000, rodada=0, pontos=0.
- All hits:
  - Stimulus: iniciar, then pulse acertou 3 cycles after each medir.
  - Required: limits step 010/020, 030/045, 050/060, 015/025. End state FIM with pontos=4, ganhou=1, fim_jogo=1.
- Timeout:
  - Stimulus: iniciar, acertou held 0.
  - Required: exactly 3 medir pulses, 11 cycles apart, in round 0.
  - With macro defined: continues to round 1 with pontos=0.
  - Without macro: FIM with rodada=0, ganhou=0.
- Simultaneous hit and timeout:
  - Stimulus: acertou=1 exactly on the last AGUARDA cycle of attempt 3.
  - Required: ACERTO taken, pontos increments.
- Stale flag and ignored iniciar:
  - Stimulus: acertou=1 during PREPARA/MEDE only; iniciar pulsed mid-game.
  - Required: no score change; no state disturbance.
- Restart from FIM:
  - Stimulus: iniciar=1 in FIM, release, then iniciar=1 again.
  - Required: passes through INICIAL; new game starts with pontos=0, rodada=0, limits 010/020.
